// File: rtl/mem_req_ctrl_if.sv
// Handshake bundle between the M-stage pipeline, mem_req_ctrl and the data memory.
// The slave modport is the controller's view; master is the surrounding environment's view.
interface mem_req_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              readEnM;
    logic              memWrtM;
    logic [DATA_W-1:0] aluFinalM;
    logic [DATA_W-1:0] wrtDataM;
    logic              memStall;
    logic              memDone;
    logic [DATA_W-1:0] memDataOut;
    logic              memEn;
    logic              memWr;
    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] memDataIn;
    logic              stallM;
    logic [DATA_W-1:0] readDataM;
    logic              readValidM;
    logic              errM;

    modport slave (
        input  readEnM, memWrtM, aluFinalM, wrtDataM,
        input  memStall, memDone, memDataOut,
        output memEn, memWr, memAddr, memDataIn,
        output stallM, readDataM, readValidM, errM
    );

    modport master (
        output readEnM, memWrtM, aluFinalM, wrtDataM,
        output memStall, memDone, memDataOut,
        input  memEn, memWr, memAddr, memDataIn,
        input  stallM, readDataM, readValidM, errM
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// M-stage memory request controller: issues one access per M instruction, stalls the
// pipeline until completion, registers load data and flags misalignment or timeout.
module mem_req_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    mem_req_ctrl_if.slave  io_bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wr;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic              r_err;

    logic              w_req;
    logic              w_aligned;
    logic              w_stall;
    logic              w_en;
    logic              w_latch;
    logic              w_capture;
    logic              w_timeout;
    logic              w_misalign;
    logic              w_cnt_clr;
    logic              w_cnt_inc;

    assign w_req     = io_bus.readEnM | io_bus.memWrtM;
    assign w_aligned = ~io_bus.aluFinalM[0];

    // memDone only counts in unstalled REQ and in WAIT; DONE ignores every input
    always_comb begin
        w_next     = r_state;
        w_stall    = 1'b0;
        w_en       = 1'b0;
        w_latch    = 1'b0;
        w_capture  = 1'b0;
        w_timeout  = 1'b0;
        w_misalign = 1'b0;
        w_cnt_clr  = 1'b0;
        w_cnt_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_aligned) begin
                        w_stall = 1'b1;
                        w_latch = 1'b1;
                        w_next  = S_REQ;
                    end else begin
                        w_misalign = 1'b1;
                    end
                end
            end
            S_REQ: begin
                w_en    = 1'b1;
                w_stall = 1'b1;
                if (!io_bus.memStall) begin
                    if (io_bus.memDone) begin
                        w_capture = ~r_wr;
                        w_next    = S_DONE;
                    end else begin
                        w_cnt_clr = 1'b1;
                        w_next    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_stall   = 1'b1;
                w_cnt_inc = 1'b1;
                if (io_bus.memDone) begin
                    w_capture = ~r_wr;
                    w_next    = S_DONE;
                end else if (r_cnt == 4'hF) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wr     <= 1'b0;
            r_cnt    <= 4'd0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_latch) begin
                r_addr  <= io_bus.aluFinalM;
                r_wdata <= io_bus.wrtDataM;
                r_wr    <= io_bus.memWrtM;
            end
            if (w_cnt_clr) begin
                r_cnt <= 4'd0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_capture) begin
                r_rdata <= io_bus.memDataOut;
            end else if (w_timeout) begin
                r_rdata <= '0;
            end
            // Both flags are one-cycle pulses landing in DONE (or the IDLE cycle after a misaligned request)
            r_rvalid <= w_capture;
            r_err    <= w_misalign | w_timeout;
        end
    end

    assign io_bus.memEn      = w_en;
    assign io_bus.memWr      = r_wr;
    assign io_bus.memAddr    = r_addr;
    assign io_bus.memDataIn  = r_wdata;
    assign io_bus.stallM     = w_stall;
    assign io_bus.readDataM  = r_rdata;
    assign io_bus.readValidM = r_rvalid;
    assign io_bus.errM       = r_err;

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 The module SHALL have one clock, clk (input, 1): all state updates on its rising edge.
REQ-002 The module SHALL have reset rst (input, 1): synchronous, active-high.
REQ-003 readEnM (input, 1) SHALL be the memory-read request of the instruction in M.
REQ-004 memWrtM (input, 1) SHALL be the memory-write request of the instruction in M.
REQ-005 aluFinalM (input, 16) SHALL be the byte address of the access.
REQ-006 wrtDataM (input, 16) SHALL be the store data.
REQ-007 memStall (input, 1) SHALL mean the memory is busy and refuses an enable this cycle.
REQ-008 memDone (input, 1) SHALL mean the memory completes the outstanding access this cycle.
REQ-009 memDataOut (input, 16) SHALL be the read data, valid only while memDone=1.
REQ-010 memEn, memWr (outputs, 1 each) SHALL be the memory enable and write-select.
REQ-011 memAddr, memDataIn (outputs, 16 each) SHALL be the memory address and write data.
REQ-012 stallM (output, 1) SHALL freeze the X/M pipeline register and all earlier stages while high.
REQ-013 readDataM (output, 16) SHALL be the registered load result.
REQ-014 readValidM (output, 1) SHALL pulse high when readDataM holds a new load result.
REQ-015 errM (output, 1) SHALL pulse high on a misaligned access or a memory timeout.

Function
REQ-016 The FSM SHALL have four states: IDLE, REQ, WAIT and DONE.
REQ-017 "req" SHALL mean readEnM|memWrtM; "aligned" SHALL mean aluFinalM[0]==0.
REQ-018 IDLE, when req & aligned:
- stallM SHALL be 1 combinationally.
- Address, data and op (wr=memWrtM) SHALL be latched into internal registers.
- Next state SHALL be REQ.
- If readEnM and memWrtM are both 1, the access SHALL be treated as a write.
REQ-019 IDLE, when req & !aligned:
- stallM SHALL be 0 and no memory access SHALL occur.
- errM SHALL be 1 for exactly the next cycle.
- The FSM SHALL remain in IDLE.
REQ-020 IDLE, when !req: stallM=0 and memEn=0.
REQ-021 REQ:
- memEn SHALL be 1; memWr, memAddr and memDataIn SHALL come from the latched registers.
- stallM SHALL be 1.
- While memStall=1 the FSM SHALL stay in REQ with all outputs unchanged.
REQ-022 REQ with memStall=0:
- memDone=1: the FSM SHALL go directly to DONE; a read SHALL capture memDataOut.
- Otherwise the next state SHALL be WAIT.
REQ-023 WAIT:
- memEn SHALL be 0 and stallM SHALL be 1.
- A 4-bit timeout counter, cleared on entry, SHALL increment every WAIT cycle.
REQ-024 WAIT with memDone=1: a read SHALL capture memDataOut into readDataM, and the next state SHALL be DONE.
REQ-025 WAIT with memDone=0 and counter==15 (16th WAIT cycle):
- Next state SHALL be DONE.
- readDataM SHALL be loaded with 16'h0000.
- errM SHALL be 1 during DONE.
REQ-026 DONE:
- stallM SHALL be 0 and memEn SHALL be 0.
- For a completed read, readValidM SHALL be 1 for this one cycle.
- All inputs SHALL be ignored, so the same M instruction is never re-issued.
- Next state SHALL be IDLE.
REQ-027 readDataM SHALL hold its value until the next read capture, timeout or reset.
REQ-028 memDone SHALL be ignored in IDLE and DONE, and in REQ while memStall=1.
REQ-029 memWr, memAddr and memDataIn SHALL be driven from the latched registers in every state; they SHALL be meaningful only while memEn=1.
REQ-030 Latency SHALL be as follows:
- Minimum (memStall=0, memDone in REQ): request cycle, REQ, DONE = 3 cycles, of which stallM is high for 2.

Reset
REQ-031 On rst=1 at a clock edge, the FSM SHALL enter IDLE regardless of the current state.
REQ-032 On that edge:
- The counter and the latched address, data and op registers SHALL be cleared to 0.
- readDataM SHALL be cleared to 16'h0000.
- readValidM and errM SHALL be cleared to 0.
REQ-033 After reset:
- memEn, memWr, memAddr, memDataIn, readValidM and errM SHALL be 0.
- stallM SHALL be 0 unless a valid request is presented.
REQ-034 Reset SHALL abandon any outstanding access; a memDone arriving after reset SHALL be ignored.

Verification
REQ-035 Reset, then idle inputs for 5 cycles -> every output 0.
REQ-036 Aligned read: readEnM=1, aluFinalM=0x0010; memDone=1 with memDataOut=0xBEEF on the 2nd WAIT cycle. Required:
- memEn high for exactly 1 cycle with memAddr=0x0010 and memWr=0.
- stallM high for 4 cycles.
- readDataM=0xBEEF with readValidM=1 in DONE.
REQ-037 Write: memWrtM=1, aluFinalM=0x0020, wrtDataM=0x1234; memStall=1 for 3 cycles, then memDone=1 in the first unstalled REQ cycle. Required:
- memEn high for 4 cycles with memDataIn=0x1234 and memWr=1.
- Then DONE, with readValidM=0.
REQ-038 Misaligned read at 0x0011 -> memEn 0, stallM 0, errM=1 for one cycle, FSM stays in IDLE.
REQ-039 Timeout: read with memDone never asserted -> 16 WAIT cycles, then DONE with errM=1, readDataM=0x0000, stallM drops.
REQ-040 rst asserted on the 2nd WAIT cycle with readEnM=0 -> next cycle IDLE with memEn 0 and stallM 0; a later memDone=1 leaves readDataM unchanged.
